reg_file_sb: RTL

REG_FILE_SB -- requirements
Module: reg_file_sb

---
 rtl/reg_file_pkg.sv | 11 +
 rtl/reg_file_rdport.sv | 41 ++++
 rtl/reg_file_sb.sv | 76 +++++++
 3 files changed

// File: rtl/reg_file_pkg.sv
// Shared defaults and encodings for the scoreboarded register file.
package reg_file_pkg;

    localparam int RF_DATA_W    = 32;
    localparam int RF_ADDR_W    = 5;
    localparam int RF_NUM_RD    = 2;

    localparam int ZERO_REG_OFF = 0;
    localparam int ZERO_REG_ON  = 1;

endpackage

// File: rtl/reg_file_rdport.sv
// One registered read port: register select, zero-register gating and
// write-first bypass, plus the matching busy bit.
module reg_file_rdport
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int ZERO_REG = ZERO_REG_ON
) (
    input  logic                                  clock,
    input  logic                                  reset_n,
    input  logic [(2**ADDR_W)-1:0][DATA_W-1:0]    i_regs,
    input  logic [(2**ADDR_W)-1:0]                i_busy_nxt,
    input  logic [ADDR_W-1:0]                     i_rd_addr,
    input  logic                                  i_wr_en,
    input  logic [ADDR_W-1:0]                     i_wr_addr,
    input  logic [DATA_W-1:0]                     i_wr_data,
    output logic [DATA_W-1:0]                     o_rd_data,
    output logic                                  o_rd_busy
);

    logic              w_zero;
    logic              w_hit;
    logic [DATA_W-1:0] w_data;

    // Zero gating outranks the bypass so a write to r0 never leaks out.
    assign w_zero = (ZERO_REG == ZERO_REG_ON) && (i_rd_addr == '0);
    assign w_hit  = i_wr_en && (i_wr_addr == i_rd_addr);
    assign w_data = w_zero ? '0 : (w_hit ? i_wr_data : i_regs[i_rd_addr]);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            o_rd_data <= '0;
            o_rd_busy <= 1'b0;
        end else begin
            o_rd_data <= w_data;
            o_rd_busy <= i_busy_nxt[i_rd_addr];
        end
    end

endmodule

// File: rtl/reg_file_sb.sv
// Multi-port register file with per-register busy scoreboard; storage,
// busy vector and write logic live here, read ports are replicated.
module reg_file_sb
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int NUM_RD   = RF_NUM_RD,
    parameter int ZERO_REG = ZERO_REG_ON
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_busy,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       iss_en,
    input  logic [ADDR_W-1:0]          iss_addr
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DEPTH-1:0][DATA_W-1:0] r_regs;
    logic [DEPTH-1:0]             r_busy;
    logic [DEPTH-1:0]             w_busy_nxt;
    logic                         w_wr_ok;
    logic                         w_iss_ok;

    assign w_wr_ok  = wr_en  && !((ZERO_REG == ZERO_REG_ON) && (wr_addr  == '0));
    assign w_iss_ok = iss_en && !((ZERO_REG == ZERO_REG_ON) && (iss_addr == '0));

    // Issue is applied after the clear so set wins on a same-register collision.
    always_comb begin
        w_busy_nxt = r_busy;
        if (wr_en) begin
            w_busy_nxt[wr_addr] = 1'b0;
        end
        if (w_iss_ok) begin
            w_busy_nxt[iss_addr] = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_regs <= '0;
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            if (w_wr_ok) begin
                r_regs[wr_addr] <= wr_data;
            end
        end
    end

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        reg_file_rdport #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .ZERO_REG (ZERO_REG)
        ) u_rdport (
            .clock      (clock),
            .reset_n    (reset_n),
            .i_regs     (r_regs),
            .i_busy_nxt (w_busy_nxt),
            .i_rd_addr  (rd_addr[g*ADDR_W +: ADDR_W]),
            .i_wr_en    (w_wr_ok),
            .i_wr_addr  (wr_addr),
            .i_wr_data  (wr_data),
            .o_rd_data  (rd_data[g*DATA_W +: DATA_W]),
            .o_rd_busy  (rd_busy[g])
        );
    end

endmodule
